// File: rtl/exu_wb_arb.sv
// Write-back arbiter: funnels ALU/MUL (buffered) and DIV (handshaked) results onto one GPR write port.
// Optional macro WB_BYPASS_EN lets an ALU result skip its empty FIFO and write one cycle earlier.
module exu_wb_arb #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            alu_valid,
   input  logic [4:0]      alu_rd_addr,
   input  logic [XLEN-1:0] alu_data,
   input  logic [XLEN-1:0] alu_tag,
   input  logic            mul_valid,
   input  logic [4:0]      mul_rd_addr,
   input  logic [XLEN-1:0] mul_data,
   input  logic [XLEN-1:0] mul_tag,
   input  logic            div_valid,
   output logic            div_ready,
   input  logic [4:0]      div_rd_addr,
   input  logic [XLEN-1:0] div_data,
   input  logic [XLEN-1:0] div_tag,
   output logic            wb_wr_en,
   output logic [4:0]      wb_rd_addr,
   output logic [XLEN-1:0] wb_data,
   output logic [XLEN-1:0] wb_tag,
   output logic            exu_stall,
   output logic            ovf_err
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam int EW = 5 + 2 * XLEN;
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
   localparam logic [CW-1:0] CNT_HI   = CW'(DEPTH - 1);

   // Source index 0 is ALU, 1 is MUL; entries are {rd, data, tag}.
   logic [1:0]    src_valid, src_keep, src_skip;
   logic [EW-1:0] src_entry [2];
   logic [1:0]    enq, deq, full, nempty, drop;
   logic [EW-1:0] head [2];
   logic [CW-1:0] cnt [2];
   logic          byp, grant;
   logic [EW-1:0] grant_entry;

   logic            rr_q, rr_d;
   logic            ovf_q, ovf_d;
   logic            wb_wr_en_q, wb_wr_en_d;
   logic [4:0]      wb_rd_addr_q, wb_rd_addr_d;
   logic [XLEN-1:0] wb_data_q, wb_data_d;
   logic [XLEN-1:0] wb_tag_q, wb_tag_d;

   assign src_valid    = {mul_valid, alu_valid};
   assign src_keep     = {mul_rd_addr != 5'd0, alu_rd_addr != 5'd0};
   assign src_skip     = {1'b0, byp};
   assign src_entry[0] = {alu_rd_addr, alu_data, alu_tag};
   assign src_entry[1] = {mul_rd_addr, mul_data, mul_tag};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_fifo
         logic [EW-1:0] mem_q [DEPTH];
         logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
         logic [CW-1:0] cnt_q, cnt_d;

         assign full[gi]   = (cnt_q == CNT_FULL);
         assign nempty[gi] = (cnt_q != '0);
         assign head[gi]   = mem_q[rptr_q];
         assign cnt[gi]    = cnt_q;
         assign drop[gi]   = src_valid[gi] & src_keep[gi] & full[gi];
         assign enq[gi]    = src_valid[gi] & src_keep[gi] & ~full[gi] & ~src_skip[gi];

         // DEPTH is a power of two, so natural pointer overflow is the modulo wrap.
         always_comb begin
            wptr_d = wptr_q;
            rptr_d = rptr_q;
            cnt_d  = cnt_q;
            if (enq[gi]) wptr_d = wptr_q + AW'(1);
            if (deq[gi]) rptr_d = rptr_q + AW'(1);
            case ({enq[gi], deq[gi]})
               2'b10:   cnt_d = cnt_q + CW'(1);
               2'b01:   cnt_d = cnt_q - CW'(1);
               default: cnt_d = cnt_q;
            endcase
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               wptr_q <= '0;
               rptr_q <= '0;
               cnt_q  <= '0;
            end else begin
               wptr_q <= wptr_d;
               rptr_q <= rptr_d;
               cnt_q  <= cnt_d;
            end
         end

         always_ff @(posedge clk) begin
            if (enq[gi]) mem_q[wptr_q] <= src_entry[gi];
         end
      end
   endgenerate

   always_comb begin
      deq         = 2'b00;
      byp         = 1'b0;
      grant       = 1'b0;
      grant_entry = '0;
      rr_d        = rr_q;
      div_ready   = div_valid & ~rst;
      if (div_valid && div_rd_addr != 5'd0) begin
         grant       = 1'b1;
         grant_entry = {div_rd_addr, div_data, div_tag};
      end
`ifdef WB_BYPASS_EN
      else if (alu_valid && src_keep[0] && !nempty[0] && !div_valid && (!nempty[1] || !rr_q)) begin
         byp         = 1'b1;
         grant       = 1'b1;
         grant_entry = src_entry[0];
         rr_d        = 1'b1;
      end
`endif
      else if (nempty[0] && (!nempty[1] || !rr_q)) begin
         deq[0]      = 1'b1;
         grant       = 1'b1;
         grant_entry = head[0];
         rr_d        = 1'b1;
      end else if (nempty[1]) begin
         deq[1]      = 1'b1;
         grant       = 1'b1;
         grant_entry = head[1];
         rr_d        = 1'b0;
      end

      ovf_d        = ovf_q | (|drop);
      wb_wr_en_d   = grant;
      wb_rd_addr_d = grant ? grant_entry[EW-1 -: 5] : wb_rd_addr_q;
      wb_data_d    = grant ? grant_entry[2*XLEN-1 -: XLEN] : wb_data_q;
      wb_tag_d     = grant ? grant_entry[XLEN-1:0] : wb_tag_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_q         <= 1'b0;
         ovf_q        <= 1'b0;
         wb_wr_en_q   <= 1'b0;
         wb_rd_addr_q <= '0;
         wb_data_q    <= '0;
         wb_tag_q     <= '0;
      end else begin
         rr_q         <= rr_d;
         ovf_q        <= ovf_d;
         wb_wr_en_q   <= wb_wr_en_d;
         wb_rd_addr_q <= wb_rd_addr_d;
         wb_data_q    <= wb_data_d;
         wb_tag_q     <= wb_tag_d;
      end
   end

   // One slot stays free for a result issued in the cycle before the stall is seen.
   assign exu_stall  = (cnt[0] >= CNT_HI) | (cnt[1] >= CNT_HI) | div_valid;
   assign wb_wr_en   = wb_wr_en_q;
   assign wb_rd_addr = wb_rd_addr_q;
   assign wb_data    = wb_data_q;
   assign wb_tag     = wb_tag_q;
   assign ovf_err    = ovf_q;
endmodule

// File: tb/tb_exu_wb_arb.sv
// Bench for exu_wb_arb: queue-based model checked every cycle plus directed literal checks.
module tb_exu_wb_arb;
   localparam int XLEN  = 32;
   localparam int DEPTH = 2;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            alu_valid = 1'b0, mul_valid = 1'b0, div_valid = 1'b0;
   logic [4:0]      alu_rd_addr = '0, mul_rd_addr = '0, div_rd_addr = '0;
   logic [XLEN-1:0] alu_data = '0, alu_tag = '0, mul_data = '0, mul_tag = '0;
   logic [XLEN-1:0] div_data = '0, div_tag = '0;
   logic            div_ready, wb_wr_en, exu_stall, ovf_err;
   logic [4:0]      wb_rd_addr;
   logic [XLEN-1:0] wb_data, wb_tag;

   exu_wb_arb #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .alu_valid(alu_valid), .alu_rd_addr(alu_rd_addr), .alu_data(alu_data), .alu_tag(alu_tag),
      .mul_valid(mul_valid), .mul_rd_addr(mul_rd_addr), .mul_data(mul_data), .mul_tag(mul_tag),
      .div_valid(div_valid), .div_ready(div_ready), .div_rd_addr(div_rd_addr),
      .div_data(div_data), .div_tag(div_tag),
      .wb_wr_en(wb_wr_en), .wb_rd_addr(wb_rd_addr), .wb_data(wb_data), .wb_tag(wb_tag),
      .exu_stall(exu_stall), .ovf_err(ovf_err)
   );

   always #5 clk = ~clk;

   int pass_cnt = 0;
   int total_cnt = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
   endtask

   // Model: per-source queues, round-robin bit, sticky overflow, expected wb registers.
   typedef struct packed {
      logic [4:0]      rd;
      logic [XLEN-1:0] data;
      logic [XLEN-1:0] tag;
   } ent_t;

   ent_t aq[$];
   ent_t mq[$];
   bit   m_rr = 0;
   bit   m_ovf = 0;
   bit   m_ready = 0;
   bit   e_wen = 0;
   ent_t e_ent = '0;

   initial begin
      forever begin
         @(posedge clk);
         if (rst) begin
            aq.delete();
            mq.delete();
            m_rr = 0; m_ovf = 0; e_wen = 0; e_ent = '0;
            m_ready = 1;
         end else begin
            int  na, nm;
            bit  byp;
            na = aq.size();
            nm = mq.size();
            byp = 0;
            e_wen = 1;
            if (div_valid && div_rd_addr != 0) e_ent = '{div_rd_addr, div_data, div_tag};
`ifdef WB_BYPASS_EN
            else if (alu_valid && alu_rd_addr != 0 && na == 0 && !div_valid && (nm == 0 || !m_rr)) begin
               byp = 1; e_ent = '{alu_rd_addr, alu_data, alu_tag}; m_rr = 1;
            end
`endif
            else if (na > 0 && (nm == 0 || !m_rr)) begin e_ent = aq.pop_front(); m_rr = 1; end
            else if (nm > 0) begin e_ent = mq.pop_front(); m_rr = 0; end
            else e_wen = 0;
            if (alu_valid && alu_rd_addr != 0 && !byp) begin
               if (na == DEPTH) m_ovf = 1;
               else aq.push_back('{alu_rd_addr, alu_data, alu_tag});
            end
            if (mul_valid && mul_rd_addr != 0) begin
               if (nm == DEPTH) m_ovf = 1;
               else mq.push_back('{mul_rd_addr, mul_data, mul_tag});
            end
         end
      end
   end

   // Every-cycle compare against the model, away from the active edge.
   initial begin
      forever begin
         @(negedge clk);
         if (m_ready) begin
            check("wb_wr_en", 64'(wb_wr_en), 64'(e_wen));
            if (e_wen) begin
               check("wb_rd_addr", 64'(wb_rd_addr), 64'(e_ent.rd));
               check("wb_data", 64'(wb_data), 64'(e_ent.data));
               check("wb_tag", 64'(wb_tag), 64'(e_ent.tag));
            end
            check("div_ready", 64'(div_ready), 64'(div_valid && !rst));
            check("exu_stall", 64'(exu_stall),
                  64'((aq.size() >= DEPTH - 1) || (mq.size() >= DEPTH - 1) || div_valid));
            check("ovf_err", 64'(ovf_err), 64'(m_ovf));
            if (wb_wr_en)
               $display("wb write rd=%0d data=%08h tag=%08h t=%0t", wb_rd_addr, wb_data, wb_tag, $time);
         end
      end
   end

   // Snapshot of the cycle just ended, for the directed literal checks.
   logic            s_wen, s_dready, s_stall, s_ovf;
   logic [4:0]      s_rd;
   logic [XLEN-1:0] s_data;
   int              wr_cnt = 0;

   task automatic tick();
      @(negedge clk);
      s_wen = wb_wr_en; s_rd = wb_rd_addr; s_data = wb_data;
      s_dready = div_ready; s_stall = exu_stall; s_ovf = ovf_err;
      if (wb_wr_en) wr_cnt++;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      alu_valid = 0; mul_valid = 0; div_valid = 0;
   endtask

   task automatic set_alu(input logic [4:0] rd, input logic [XLEN-1:0] d, input logic [XLEN-1:0] t);
      alu_valid = 1; alu_rd_addr = rd; alu_data = d; alu_tag = t;
   endtask

   task automatic set_mul(input logic [4:0] rd, input logic [XLEN-1:0] d, input logic [XLEN-1:0] t);
      mul_valid = 1; mul_rd_addr = rd; mul_data = d; mul_tag = t;
   endtask

   task automatic set_div(input logic [4:0] rd, input logic [XLEN-1:0] d, input logic [XLEN-1:0] t);
      div_valid = 1; div_rd_addr = rd; div_data = d; div_tag = t;
   endtask

   initial begin
      int issued, guard;
      @(posedge clk); #1;
      tick(); tick();
      rst = 0;
      tick();
      check("reset_wen", 64'(s_wen), 64'd0);
      check("reset_rd_data", {27'd0, s_rd, s_data}, 64'd0);
      check("reset_stall", 64'(s_stall), 64'd0);
      check("reset_ovf", 64'(s_ovf), 64'd0);

      // Single ALU result latency
      set_alu(5'd5, 32'h1234, 32'h11);
      tick();
      idle();
      tick();
`ifndef WB_BYPASS_EN
      check("alu_lat_early", 64'(s_wen), 64'd0);
      tick();
`endif
      check("alu_lat_wen", 64'(s_wen), 64'd1);
      check("alu_lat_rd", 64'(s_rd), 64'd5);
      check("alu_lat_data", 64'(s_data), 64'h1234);
      check("alu_lat_ovf", 64'(s_ovf), 64'd0);
      tick(); tick();

      // Dual streams honouring exu_stall
      wr_cnt = 0; issued = 0; guard = 0;
      while (issued < 4 && guard < 30) begin
         if (!exu_stall) begin
            set_alu(5'(8 + issued), 32'hA000 + issued, 32'h100 + issued);
            set_mul(5'(16 + issued), 32'hB000 + issued, 32'h200 + issued);
            issued++;
         end else idle();
         tick();
         guard++;
      end
      idle();
      repeat (6) tick();
      check("stream_issued", 64'(issued), 64'd4);
      check("stream_writes", 64'(wr_cnt), 64'd8);
      check("stream_ovf", 64'(s_ovf), 64'd0);

      // DIV pre-empts two non-empty FIFOs
      set_alu(5'd1, 32'h1, 32'h301);
      set_mul(5'd2, 32'h2, 32'h302);
      tick();
      idle();
      set_div(5'd7, 32'hDEAD, 32'h303);
      tick();
      check("div_ready_hi", 64'(s_dready), 64'd1);
      check("div_stall_hi", 64'(s_stall), 64'd1);
      idle();
      tick();
      check("div_first_wen", 64'(s_wen), 64'd1);
      check("div_first_rd", 64'(s_rd), 64'd7);
      check("div_first_data", 64'(s_data), 64'hDEAD);
      check("div_ready_lo", 64'(s_dready), 64'd0);
      repeat (4) tick();

      // rd==0 discards
      set_alu(5'd0, 32'hFFFF, 32'h400);
      tick();
      idle();
      tick();
      check("rd0_alu_stall", 64'(s_stall), 64'd0);
      tick();
      check("rd0_alu_wen", 64'(s_wen), 64'd0);
      set_div(5'd0, 32'h5555, 32'h401);
      tick();
      check("rd0_div_ready", 64'(s_dready), 64'd1);
      idle();
      tick();
      check("rd0_div_wen", 64'(s_wen), 64'd0);
      tick();

      // Overflow: DEPTH+1 ALU enqueues while DIV holds the port
      set_div(5'd3, 32'hD1, 32'h500);
      for (int k = 0; k < DEPTH + 1; k++) begin
         set_alu(5'(10 + k), 32'hC000 + k, 32'h510 + k);
         tick();
      end
      idle();
      tick();
      check("ovf_set", 64'(s_ovf), 64'd1);
      repeat (4) tick();
      check("ovf_sticky", 64'(s_ovf), 64'd1);
      rst = 1;
      tick();
      rst = 0;
      tick();
      check("ovf_cleared", 64'(s_ovf), 64'd0);

      // Reset with one entry buffered in each FIFO
      set_alu(5'd20, 32'hE0, 32'h600);
      set_mul(5'd21, 32'hE1, 32'h601);
      tick();
      idle();
      rst = 1;
      tick();
      rst = 0;
      wr_cnt = 0;
      tick();
      check("rst_mid_wen", 64'(s_wen), 64'd0);
      check("rst_mid_rd_data", {27'd0, s_rd, s_data}, 64'd0);
      check("rst_mid_stall_ovf", {62'd0, s_stall, s_ovf}, 64'd0);
      repeat (5) tick();
      check("rst_mid_no_write", 64'(wr_cnt), 64'd0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
